lif_param_sequencer: RTL

//  Host-side controller that programs the LIF neuron parameter loader over its 2-wire serial link.

---
 rtl/lif_param_sequencer_if.sv | 35 +++
 rtl/lif_param_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lif_param_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | lif_param_sequencer_if : config handshake, serial load link and status     |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
interface lif_param_sequencer_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_weight_a;
    logic [2:0] cfg_weight_b;
    logic [1:0] cfg_leak;
    logic [7:0] cfg_thr_min;
    logic [7:0] cfg_thr_max;
    logic       load_enable;
    logic       serial_data_out;
    logic       params_ready_in;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    modport slave (
        input  cfg_valid, cfg_weight_a, cfg_weight_b, cfg_leak, cfg_thr_min, cfg_thr_max,
        input  params_ready_in,
        output cfg_ready, load_enable, serial_data_out, busy, done, error, err_code
    );

    modport master (
        output cfg_valid, cfg_weight_a, cfg_weight_b, cfg_leak, cfg_thr_min, cfg_thr_max,
        output params_ready_in,
        input  cfg_ready, load_enable, serial_data_out, busy, done, error, err_code
    );
endinterface
`default_nettype wire

// File: rtl/lif_param_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | lif_param_sequencer : range-checks a LIF parameter set and shifts it out   |
// | as a 40-bit MSB-first frame. Optional macro: LIF_SEQ_TIMEOUT_EN            |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module lif_param_sequencer #(
    parameter int LEAD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              enable,
    lif_param_sequencer_if.slave   bus
);

    localparam int LEAD_W = (LEAD_CYCLES > 1) ? $clog2(LEAD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_LEAD     = 3'd2,
        S_SHIFT    = 3'd3,
        S_WAIT_RDY = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [39:0]         frame_q, frame_d;
    logic [5:0]          idx_q, idx_d;
    logic [LEAD_W-1:0]   lead_q, lead_d;
    logic                load_enable_q, load_enable_d;
    logic                sdo_q, sdo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                cfg_ready_q, cfg_ready_d;
`ifdef LIF_SEQ_TIMEOUT_EN
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
`else
    logic                unused_cfg;
    assign unused_cfg = ^{bus.params_ready_in, TO_W'(TIMEOUT_CYCLES)};
`endif

    // Outputs are computed from the next state so they change on the same edge as the state.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        idx_d         = idx_q;
        lead_d        = lead_q;
        load_enable_d = load_enable_q;
        sdo_d         = sdo_q;
        done_d        = 1'b0;
        error_d       = 1'b0;
        err_code_d    = err_code_q;
`ifdef LIF_SEQ_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_valid) begin
                    state_d    = S_CHECK;
                    frame_d    = {5'b0, bus.cfg_weight_a, 5'b0, bus.cfg_weight_b,
                                  6'b0, bus.cfg_leak, bus.cfg_thr_min, bus.cfg_thr_max};
                    err_code_d = 2'b00;
                end
            end
            S_CHECK: begin
                if (frame_q[15:8] > frame_q[7:0]) begin
                    state_d    = S_ERR;
                    error_d    = 1'b1;
                    err_code_d = 2'b01;
                end else begin
                    state_d       = S_LEAD;
                    load_enable_d = 1'b1;
                    sdo_d         = 1'b0;
                    lead_d        = '0;
                end
            end
            S_LEAD: begin
                if (lead_q == LEAD_W'(LEAD_CYCLES - 1)) begin
                    state_d = S_SHIFT;
                    idx_d   = 6'd39;
                    sdo_d   = frame_q[39];
                end else begin
                    lead_d = lead_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (idx_q == 6'd0) begin
                    load_enable_d = 1'b0;
                    sdo_d         = 1'b0;
`ifdef LIF_SEQ_TIMEOUT_EN
                    state_d       = S_WAIT_RDY;
                    to_cnt_d      = '0;
`else
                    state_d       = S_DONE;
                    done_d        = 1'b1;
`endif
                end else begin
                    idx_d = idx_q - 6'd1;
                    sdo_d = frame_q[idx_q - 6'd1];
                end
            end
`ifdef LIF_SEQ_TIMEOUT_EN
            // A ready flag arriving on the final wait cycle still counts as success.
            S_WAIT_RDY: begin
                if (bus.params_ready_in) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = S_ERR;
                    error_d    = 1'b1;
                    err_code_d = 2'b10;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d      = (state_d != S_IDLE);
        cfg_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            frame_q       <= '0;
            idx_q         <= '0;
            lead_q        <= '0;
            load_enable_q <= 1'b0;
            sdo_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= 2'b00;
            cfg_ready_q   <= 1'b1;
`ifdef LIF_SEQ_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else if (enable) begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            idx_q         <= idx_d;
            lead_q        <= lead_d;
            load_enable_q <= load_enable_d;
            sdo_q         <= sdo_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
            cfg_ready_q   <= cfg_ready_d;
`ifdef LIF_SEQ_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    assign bus.cfg_ready       = cfg_ready_q;
    assign bus.load_enable     = load_enable_q;
    assign bus.serial_data_out = sdo_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.error           = error_q;
    assign bus.err_code        = err_code_q;

endmodule
`default_nettype wire
